ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter for the single-port 16-bit × 256-word program/data RAM. It shares the RAM between the CPU (PC fetch and load/store path) and a host loader/debug port. Round-robin arbitration resolves contention, host lock gives the host a burst, and a starvation timer guarantees CPU progress. It sits between the counter/controller address path and the RAM instance, and it reports CPU stalls back to the controller.

## Interface
Parameters:
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 8, RAM address width
- LOCK_MAX, 64, max consecutive host-locked cycles while cpu_req pends before CPU is forced one grant (1..255)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- cpu_req  in  1  CPU access request; held with fields stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data (datapath B)
- cpu_gnt  out  1  access issued to RAM this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  read data valid (one cycle after read grant)
- cpu_rdata  out  DATA_WIDTH  read data
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  host equivalents
- host_lock  in  1  while high with host_req, host keeps ownership
- host_gnt, host_rvalid, host_rdata  out  1/1/DATA_WIDTH  host equivalents
- ram_addr  out  ADDR_WIDTH  to RAM read/write address
- ram_we  out  1  to RAM mwrite
- ram_wdata  out  DATA_WIDTH  to RAM in
- ram_rdata  in  DATA_WIDTH  RAM out (synchronous read, 1-cycle latency)

## Operation
- States: IDLE, CPU_OWN, HOST_OWN, HOST_LOCK.
- The grant decision is combinational from the current state and requests. At most one grant per cycle, and a grant always means one RAM access that cycle.
- Arbitration (not locked):
  - Single requester wins.
  - When both request, the requester not granted last wins. A `last` flag is updated on every grant.
  - After reset, `last` = HOST, so the CPU wins the first tie.
- Lock:
  - host_gnt with host_lock=1 enters HOST_LOCK.
  - In HOST_LOCK, only the host is granted, and it may issue one access per cycle.
  - HOST_LOCK is exited when host_lock=0 or host_req=0 is sampled. The next state is then arbitrated normally.
- Starvation:
  - `starve_cnt` (8-bit) counts cycles in HOST_LOCK with cpu_req=1 and no cpu_gnt.
  - At starve_cnt == LOCK_MAX, the next cycle grants the CPU (host_gnt=0) and clears the counter. The lock then resumes if it is still asserted.
  - The counter clears whenever cpu_gnt=1 or cpu_req=0.
- Mux: ram_addr/ram_we/ram_wdata come from the granted port. With no grant, ram_we=0 and ram_addr holds its last value.
- Read return:
  - Registered `rd_owner` plus `rd_pend` steer ram_rdata to the owner's rdata and pulse that port's rvalid for exactly one cycle.
  - Writes produce no rvalid.
  - The rdata of the non-owning port is 0.
- Write-then-read to the same address on consecutive cycles returns the new data. This is a RAM property; the arbiter adds no forwarding.

## Timing
- Reset (reset=0 at an edge): state=IDLE, last=HOST, starve_cnt=0, rd_pend=0.
  - All gnt, rvalid and stall outputs are 0; ram_we=0, ram_addr=0, and rdata outputs are 0.
  - A read in flight at reset is dropped, with no rvalid.
- Grant latency: 0 cycles for an uncontended request.
- Read data: rvalid and rdata appear on cycle N+1 for a read granted at cycle N. Back-to-back reads give 1 word per cycle.
- Worst-case CPU wait under lock: LOCK_MAX+1 cycles.
- cpu_stall is combinational and is valid in the same cycle as cpu_req.
- Requests dropped before grant are legal and are simply not served.

## Structure
- Shared package `ram_arb_pkg`: state enum (IDLE, CPU_OWN, HOST_OWN, HOST_LOCK), owner encoding (OWN_CPU=0, OWN_HOST=1), default LOCK_MAX.
- One sub-module, `starve_timer`: the 8-bit counter with clear/inc/hit outputs.
- Everything else is flat: FSM, grant logic, mux, read-return register.

## Test plan
- Reset then CPU-only read of addr 0x05 (RAM=0x1234): cpu_gnt is high the same cycle; cpu_rvalid=1 and cpu_rdata=0x1234 the next cycle; host outputs stay 0.
- Simultaneous cpu_req and host_req held for 4 cycles: grants go CPU, HOST, CPU, HOST, and cpu_stall is high exactly on the host cycles.
- Host write 0xBEEF to 0x10, then CPU read of 0x10 next cycle: cpu_rdata=0xBEEF with one rvalid pulse, and no host_rvalid.
- host_lock held for 200 cycles with LOCK_MAX=64 and cpu_req constant:
  - The CPU is granted only on cycles 65, 130 and 195 of the lock.
  - The host is granted on all other cycles, and the counter clears after each CPU grant.
- reset=0 asserted in the cycle after a host read grant: no host_rvalid, all outputs 0; after release, the first tie goes to the CPU.
- host_lock dropped mid-burst while cpu_req is pending: the CPU is granted on the next cycle, and HOST_LOCK is exited.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the program/data RAM arbiter.
// State, owner encoding and default lock budget.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_OWN,
    HOST_OWN,
    HOST_LOCK
  } arb_state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  localparam int LOCK_MAX_DEF = 64;

endpackage

// File: rtl/starve_timer.sv
// Counts CPU wait cycles under host lock.
// hit forces one CPU grant when the budget is used up.
module starve_timer #(
  parameter int LOCK_MAX = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign hit = (cnt_q == 8'(LOCK_MAX));

endmodule

// File: rtl/ram_arbiter.sv
// CPU/host arbiter for the single-port program/data RAM.
// Round-robin, host lock bursts, starvation-bounded CPU wait.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_lock,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  arb_state_e            state_q, state_d;
  owner_e                last_q, last_d;
  owner_e                rd_owner_q, rd_owner_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic locked;
  logic hit;
  logic cpu_g;
  logic host_g;
  logic st_inc;
  logic st_clr;

  assign locked = (state_q == HOST_LOCK) && host_req && host_lock;

  // Grants are gated by reset so nothing reaches the RAM while held.
  always_comb begin
    cpu_g  = 1'b0;
    host_g = 1'b0;
    if (!reset) begin
      cpu_g  = 1'b0;
      host_g = 1'b0;
    end else if (locked) begin
      if (cpu_req && hit) cpu_g = 1'b1;
      else host_g = 1'b1;
    end else if (cpu_req && host_req) begin
      if (last_q == OWN_HOST) cpu_g = 1'b1;
      else host_g = 1'b1;
    end else begin
      cpu_g  = cpu_req;
      host_g = host_req;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    addr_d     = addr_q;
    unique case (1'b1)
      cpu_g: begin
        state_d    = locked ? HOST_LOCK : CPU_OWN;
        last_d     = OWN_CPU;
        rd_pend_d  = ~cpu_we;
        rd_owner_d = OWN_CPU;
        addr_d     = cpu_addr;
      end
      host_g: begin
        state_d    = host_lock ? HOST_LOCK : HOST_OWN;
        last_d     = OWN_HOST;
        rd_pend_d  = ~host_we;
        rd_owner_d = OWN_HOST;
        addr_d     = host_addr;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= OWN_HOST;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CPU;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      addr_q     <= addr_d;
    end
  end

  assign st_inc = (state_q == HOST_LOCK) && cpu_req && !cpu_g;
  assign st_clr = cpu_g || !cpu_req;

  starve_timer #(
    .LOCK_MAX(LOCK_MAX)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (st_inc),
    .clr  (st_clr),
    .hit  (hit)
  );

  assign cpu_gnt   = cpu_g;
  assign host_gnt  = host_g;
  assign cpu_stall = reset && cpu_req && !cpu_g;

  assign ram_we    = (cpu_g && cpu_we) || (host_g && host_we);
  assign ram_addr  = reset ? addr_d : '0;
  assign ram_wdata = cpu_g  ? cpu_wdata :
                     host_g ? host_wdata : '0;

  assign cpu_rvalid  = reset && rd_pend_q && (rd_owner_q == OWN_CPU);
  assign host_rvalid = reset && rd_pend_q && (rd_owner_q == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? ram_rdata : '0;
  assign host_rdata  = host_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural
// synchronous-read RAM attached to its RAM port.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        host_req, host_we, host_lock;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic [15:0] mem [256];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_lock  (host_lock),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // RAM model; word 0x05 is seeded while reset is held.
  always @(posedge clk) begin
    if (!reset) mem[5] <= 16'h1234;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    host_lock = 0;
  endtask

  initial begin
    logic exp_c;
    reset = 0;
    idle_all();
    tick();
    tick();
    @(negedge clk);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    tick();
    reset = 1;

    // CPU-only read of 0x05
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    @(negedge clk);
    check("t1_cpu_gnt", cpu_gnt, 1);
    check("t1_cpu_stall", cpu_stall, 0);
    check("t1_host_gnt", host_gnt, 0);
    check("t1_ram_addr", ram_addr, 8'h05);
    tick();
    cpu_req = 0;
    @(negedge clk);
    check("t1_cpu_rvalid", cpu_rvalid, 1);
    check("t1_cpu_rdata", cpu_rdata, 16'h1234);
    check("t1_host_rvalid", host_rvalid, 0);
    check("t1_host_rdata", host_rdata, 0);
    check("t1_ram_addr_hold", ram_addr, 8'h05);
    tick();
    check("t1_rvalid_once", cpu_rvalid, 0);

    // Host write 0xBEEF to 0x10, CPU reads it back
    host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 16'hBEEF;
    @(negedge clk);
    check("t3_host_gnt", host_gnt, 1);
    check("t3_ram_we", ram_we, 1);
    check("t3_ram_wdata", ram_wdata, 16'hBEEF);
    tick();
    host_req = 0; host_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    @(negedge clk);
    check("t3_cpu_gnt", cpu_gnt, 1);
    check("t3_wr_no_rvalid", host_rvalid, 0);
    tick();
    cpu_req = 0;
    host_req = 1; host_we = 0; host_addr = 8'h05;
    @(negedge clk);
    check("t3_cpu_rvalid", cpu_rvalid, 1);
    check("t3_cpu_rdata", cpu_rdata, 16'hBEEF);
    check("t3_host_rvalid", host_rvalid, 0);
    check("t3_host_gnt", host_gnt, 1);
    tick();
    host_req = 0;
    @(negedge clk);
    check("t3_host_rvalid2", host_rvalid, 1);
    check("t3_host_rdata", host_rdata, 16'h1234);
    check("t3_cpu_rvalid2", cpu_rvalid, 0);
    check("t3_cpu_rdata0", cpu_rdata, 0);
    tick();

    // Tie held 4 cycles: CPU, HOST, CPU, HOST
    cpu_req = 1; cpu_addr = 8'h01;
    host_req = 1; host_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("tie%0d_cpu_gnt", i), cpu_gnt, (i % 2 == 0));
      check($sformatf("tie%0d_host_gnt", i), host_gnt, (i % 2 == 1));
      check($sformatf("tie%0d_stall", i), cpu_stall, (i % 2 == 1));
      tick();
    end
    idle_all();
    tick();

    // Host lock burst with a waiting CPU
    host_req = 1; host_lock = 1; host_we = 1;
    host_addr = 8'h20; host_wdata = 16'h5A5A;
    @(negedge clk);
    check("lk0_host_gnt", host_gnt, 1);
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h03;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      exp_c = (k == 65) || (k == 130) || (k == 195);
      check($sformatf("lk%0d_cpu_gnt", k), cpu_gnt, exp_c);
      check($sformatf("lk%0d_host_gnt", k), host_gnt, !exp_c);
      tick();
    end
    host_lock = 0;
    @(negedge clk);
    check("unlk_cpu_gnt", cpu_gnt, 1);
    check("unlk_host_gnt", host_gnt, 0);
    tick();
    @(negedge clk);
    check("unlk2_host_gnt", host_gnt, 1);
    check("unlk2_stall", cpu_stall, 1);
    tick();
    @(negedge clk);
    check("unlk3_cpu_gnt", cpu_gnt, 1);
    tick();
    idle_all();
    tick();

    // Reset right after a host read grant
    host_req = 1; host_we = 0; host_addr = 8'h05;
    @(negedge clk);
    check("rr_host_gnt", host_gnt, 1);
    tick();
    host_req = 0;
    cpu_req = 1;
    reset = 0;
    @(negedge clk);
    check("rr_host_rvalid", host_rvalid, 0);
    check("rr_host_rdata", host_rdata, 0);
    check("rr_cpu_gnt", cpu_gnt, 0);
    check("rr_cpu_stall", cpu_stall, 0);
    check("rr_ram_addr", ram_addr, 0);
    check("rr_ram_we", ram_we, 0);
    tick();
    reset = 1;
    cpu_req = 1; cpu_addr = 8'h01;
    host_req = 1; host_addr = 8'h02;
    @(negedge clk);
    check("rr_tie_cpu_gnt", cpu_gnt, 1);
    check("rr_tie_host_gnt", host_gnt, 0);
    check("rr_post_rvalid", host_rvalid, 0);
    tick();
    idle_all();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
